sm_instr_wb_bridge: RTL and testbench
=====================================

// Module: sm_instr_wb_bridge
// PURPOSE
// Sits directly downstream of the Sensor Manager statemachine. It latches the 16-bit instruction word read from
// Sensor Memory, decodes it into the control flags the statemachine consumes, and forwards its Wishbone strobes to the
// register-file slave bus. It returns a one-cycle ACK, captures read data for write-back to Sensor Memory, and guards
// every transfer with an ACK timeout.
// PARAMETERS
// JUMP_REG_ADR   7'h01    register address decoded as a jump instruction (CONTROL_JUMP_REG_DCD)
// POLL_ADR_LO    7'h40    lowest register address requiring busy-poll (WB_BUSY_POLL_O)
// POLL_ADR_HI    7'h4F    highest register address requiring busy-poll, inclusive
// ACK_TIMEOUT    255      slave-side cycles allowed before a transfer is force-terminated (1..255)
// PORTS
// CLK_IN               in   1   system clock
// RESET_IN             in   1   asynchronous reset, active high
// SM_READ_SELECT       in   1   instruction word on MEM_RD_DATA is valid this cycle
// SM_WRITE_SELECT      in   1   current read transfer result is to be written back to Sensor Memory
// SM_INSTR_PTR         in   8   current instruction address
// MEM_RD_DATA          in   16  instruction word {save[15], reg_adr[14:8], data[7:0]}
// WB_WE_I/STB_I/CYC_I  in   1   statemachine-side Wishbone master strobes
// WB_ACK_O             out  1   one-cycle transfer-complete pulse to the statemachine
// CONTROL_JUMP_REG_DCD out  1   IR[14:8]==JUMP_REG_ADR
// SAVE_REG_2_MEM       out  1   IR[15]
// WB_BUSY_POLL_O       out  1   POLL_ADR_LO<=IR[14:8]<=POLL_ADR_HI
// SM_READ_DATA         out  8   IR[7:0] (jump target / write data)
// WBS_ADR_O            out  7   slave address
// WBS_DAT_O            out  8   slave write data
// WBS_WE_O/STB_O/CYC_O out  1   slave strobes
// WBS_DAT_I            in   8   slave read data
// WBS_ACK_I            in   1   slave acknowledge
// MEM_WR_EN            out  1   one-cycle Sensor Memory write strobe
// MEM_WR_ADR           out  8   write-back address
// MEM_WR_DATA          out  8   write-back data
// ERR_O                out  1   sticky timeout flag
// ERR_CLR_I            in   1   clears ERR_O; if a timeout occurs in the same cycle, the set wins
// BEHAVIOUR
// - Reset: IR=16'h0000, FSM=IDLE, all outputs 0. Decoded outputs are pure functions of IR.
// - IR loads MEM_RD_DATA on the clock edge where SM_READ_SELECT=1. Decodes are valid the next cycle.
// - IR holds during XFER/ACKD. A SM_READ_SELECT during XFER is ignored (protocol violation).
// - FSM states IDLE, XFER, ACKD:
//   IDLE->XFER when CYC_I&STB_I. At that edge: register WBS_ADR_O=IR[14:8], WBS_DAT_O=IR[7:0], WBS_WE_O=WB_WE_I;
//   STB_O=CYC_O=1 and counter=0.
//   XFER: strobes held. The counter increments each cycle without WBS_ACK_I.
//   XFER->ACKD on WBS_ACK_I. At that edge: strobes drop, WB_ACK_O<=1.
//     If the transfer is a read, MEM_WR_DATA<=WBS_DAT_I and MEM_WR_ADR<=SM_INSTR_PTR.
//     If it is a read and SM_WRITE_SELECT=1, MEM_WR_EN<=1.
//   XFER->ACKD on timeout (counter==ACK_TIMEOUT-1, no ack). Same as above, but read data is 8'hFF and ERR_O<=1.
//   XFER->IDLE if CYC_I drops (abort). Strobes drop, no ACK, no MEM_WR_EN.
//   ACKD->IDLE unconditionally. WB_ACK_O/MEM_WR_EN clear, so each is exactly one cycle.
//   STB_I in ACKD is ignored, because it is the pre-ACK value.
// - Latency: CYC_I&STB_I sampled at edge 0, slave strobes visible in cycle 1; WBS_ACK_I in cycle k gives WB_ACK_O in
//   cycle k+1. Back-to-back transfer (SAVE write then read): the new request is seen in IDLE the cycle after ACKD.
// - WBS_ACK_I outside XFER is ignored. WBS_ACK_I on the timeout cycle counts as a normal ack (no error).
// - Asynchronous reset mid-transfer drops every strobe immediately. No ACK or memory write is issued.
// TESTING
// 1 Reset; MEM_RD_DATA=16'h0155, SM_READ_SELECT pulse -> next cycle CONTROL_JUMP_REG_DCD=1, SAVE=0, SM_READ_DATA=8'h55.
// 2 IR=16'h4233, STB/CYC/WE=1; slave acks 3 cycles after STB_O -> WBS_ADR_O=7'h42, DAT_O=8'h33, WB_BUSY_POLL_O=1,
//   exactly one WB_ACK_O pulse, no MEM_WR_EN.
// 3 IR=16'h8510, SM_WRITE_SELECT=1, read; slave returns 8'hA7 with ack; SM_INSTR_PTR=8'h12
//   -> MEM_WR_EN one cycle, MEM_WR_ADR=8'h12, MEM_WR_DATA=8'hA7, coincident with WB_ACK_O.
// 4 Slave never acks, ACK_TIMEOUT=4 -> strobes drop after 4 cycles, WB_ACK_O pulse, read data 8'hFF, ERR_O=1;
//   ERR_CLR_I -> ERR_O=0.
// 5 Write ack followed by read request in the cycle after ACKD -> second slave cycle launches, with WE=0.
// 6 Assert RESET_IN during XFER -> all strobes and outputs 0 immediately; FSM IDLE, no ACK after release.

Source files
------------

// File: rtl/sm_instr_wb_bridge.sv
// rtl/sm_instr_wb_bridge.sv - Sensor Manager instruction latch/decode and Wishbone slave-bus bridge
// Holds the instruction word, decodes control flags and runs one guarded slave transfer per request.
module sm_instr_wb_bridge #(
    parameter logic [6:0]  JUMP_REG_ADR = 7'h01,
    parameter logic [6:0]  POLL_ADR_LO  = 7'h40,
    parameter logic [6:0]  POLL_ADR_HI  = 7'h4F,
    parameter int unsigned ACK_TIMEOUT  = 255
) (
    input  logic        CLK_IN,
    input  logic        RESET_IN,
    input  logic        SM_READ_SELECT,
    input  logic        SM_WRITE_SELECT,
    input  logic [7:0]  SM_INSTR_PTR,
    input  logic [15:0] MEM_RD_DATA,
    input  logic        WB_WE_I,
    input  logic        WB_STB_I,
    input  logic        WB_CYC_I,
    output logic        WB_ACK_O,
    output logic        CONTROL_JUMP_REG_DCD,
    output logic        SAVE_REG_2_MEM,
    output logic        WB_BUSY_POLL_O,
    output logic [7:0]  SM_READ_DATA,
    output logic [6:0]  WBS_ADR_O,
    output logic [7:0]  WBS_DAT_O,
    output logic        WBS_WE_O,
    output logic        WBS_STB_O,
    output logic        WBS_CYC_O,
    input  logic [7:0]  WBS_DAT_I,
    input  logic        WBS_ACK_I,
    output logic        MEM_WR_EN,
    output logic [7:0]  MEM_WR_ADR,
    output logic [7:0]  MEM_WR_DATA,
    output logic        ERR_O,
    input  logic        ERR_CLR_I
);

    typedef enum logic [1:0] {IDLE, XFER, ACKD} state_t;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [6:0]  adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;
    logic        we_q, we_d;
    logic        stb_q, stb_d;
    logic        ack_q, ack_d;
    logic        mem_en_q, mem_en_d;
    logic [7:0]  mem_adr_q, mem_adr_d;
    logic [7:0]  mem_dat_q, mem_dat_d;
    logic        err_q, err_d;

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q   <= IDLE;
            ir_q      <= 16'h0000;
            cnt_q     <= 8'h00;
            adr_q     <= 7'h00;
            dat_q     <= 8'h00;
            we_q      <= 1'b0;
            stb_q     <= 1'b0;
            ack_q     <= 1'b0;
            mem_en_q  <= 1'b0;
            mem_adr_q <= 8'h00;
            mem_dat_q <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            stb_q     <= stb_d;
            ack_q     <= ack_d;
            mem_en_q  <= mem_en_d;
            mem_adr_q <= mem_adr_d;
            mem_dat_q <= mem_dat_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        stb_d     = stb_q;
        ack_d     = 1'b0;
        mem_en_d  = 1'b0;
        mem_adr_d = mem_adr_q;
        mem_dat_d = mem_dat_q;
        // A timeout in the same cycle as a clear overrides it below.
        err_d     = err_q & ~ERR_CLR_I;

        unique case (state_q)
            IDLE: begin
                if (SM_READ_SELECT) begin
                    ir_d = MEM_RD_DATA;
                end
                if (WB_CYC_I && WB_STB_I) begin
                    state_d = XFER;
                    adr_d   = ir_q[14:8];
                    dat_d   = ir_q[7:0];
                    we_d    = WB_WE_I;
                    stb_d   = 1'b1;
                    cnt_d   = 8'h00;
                end
            end
            XFER: begin
                if (!WB_CYC_I) begin
                    state_d = IDLE;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                end else if (WBS_ACK_I || (cnt_q == TMO_LAST)) begin
                    state_d = ACKD;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    ack_d   = 1'b1;
                    if (!we_q) begin
                        mem_dat_d = WBS_ACK_I ? WBS_DAT_I : 8'hFF;
                        mem_adr_d = SM_INSTR_PTR;
                        mem_en_d  = SM_WRITE_SELECT;
                    end
                    if (!WBS_ACK_I) begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ACKD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign CONTROL_JUMP_REG_DCD = (ir_q[14:8] == JUMP_REG_ADR);
    assign SAVE_REG_2_MEM       = ir_q[15];
    assign WB_BUSY_POLL_O       = (ir_q[14:8] >= POLL_ADR_LO) && (ir_q[14:8] <= POLL_ADR_HI);
    assign SM_READ_DATA         = ir_q[7:0];

    assign WBS_ADR_O   = adr_q;
    assign WBS_DAT_O   = dat_q;
    assign WBS_WE_O    = we_q;
    assign WBS_STB_O   = stb_q;
    assign WBS_CYC_O   = stb_q;
    assign WB_ACK_O    = ack_q;
    assign MEM_WR_EN   = mem_en_q;
    assign MEM_WR_ADR  = mem_adr_q;
    assign MEM_WR_DATA = mem_dat_q;
    assign ERR_O       = err_q;

endmodule

// File: tb/tb_sm_instr_wb_bridge.sv
// tb/tb_sm_instr_wb_bridge.sv - scoreboard bench for sm_instr_wb_bridge
module tb_sm_instr_wb_bridge;

    localparam int TMO = 4;

    logic        CLK_IN = 1'b0;
    logic        RESET_IN = 1'b1;
    logic        SM_READ_SELECT = 1'b0;
    logic        SM_WRITE_SELECT = 1'b0;
    logic [7:0]  SM_INSTR_PTR = 8'h00;
    logic [15:0] MEM_RD_DATA = 16'h0000;
    logic        WB_WE_I = 1'b0;
    logic        WB_STB_I = 1'b0;
    logic        WB_CYC_I = 1'b0;
    logic        WB_ACK_O;
    logic        CONTROL_JUMP_REG_DCD;
    logic        SAVE_REG_2_MEM;
    logic        WB_BUSY_POLL_O;
    logic [7:0]  SM_READ_DATA;
    logic [6:0]  WBS_ADR_O;
    logic [7:0]  WBS_DAT_O;
    logic        WBS_WE_O;
    logic        WBS_STB_O;
    logic        WBS_CYC_O;
    logic [7:0]  WBS_DAT_I = 8'h00;
    logic        WBS_ACK_I = 1'b0;
    logic        MEM_WR_EN;
    logic [7:0]  MEM_WR_ADR;
    logic [7:0]  MEM_WR_DATA;
    logic        ERR_O;
    logic        ERR_CLR_I = 1'b0;

    sm_instr_wb_bridge #(
        .JUMP_REG_ADR(7'h01),
        .POLL_ADR_LO (7'h40),
        .POLL_ADR_HI (7'h4F),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .CLK_IN              (CLK_IN),
        .RESET_IN            (RESET_IN),
        .SM_READ_SELECT      (SM_READ_SELECT),
        .SM_WRITE_SELECT     (SM_WRITE_SELECT),
        .SM_INSTR_PTR        (SM_INSTR_PTR),
        .MEM_RD_DATA         (MEM_RD_DATA),
        .WB_WE_I             (WB_WE_I),
        .WB_STB_I            (WB_STB_I),
        .WB_CYC_I            (WB_CYC_I),
        .WB_ACK_O            (WB_ACK_O),
        .CONTROL_JUMP_REG_DCD(CONTROL_JUMP_REG_DCD),
        .SAVE_REG_2_MEM      (SAVE_REG_2_MEM),
        .WB_BUSY_POLL_O      (WB_BUSY_POLL_O),
        .SM_READ_DATA        (SM_READ_DATA),
        .WBS_ADR_O           (WBS_ADR_O),
        .WBS_DAT_O           (WBS_DAT_O),
        .WBS_WE_O            (WBS_WE_O),
        .WBS_STB_O           (WBS_STB_O),
        .WBS_CYC_O           (WBS_CYC_O),
        .WBS_DAT_I           (WBS_DAT_I),
        .WBS_ACK_I           (WBS_ACK_I),
        .MEM_WR_EN           (MEM_WR_EN),
        .MEM_WR_ADR          (MEM_WR_ADR),
        .MEM_WR_DATA         (MEM_WR_DATA),
        .ERR_O               (ERR_O),
        .ERR_CLR_I           (ERR_CLR_I)
    );

    always #5 CLK_IN = ~CLK_IN;

    typedef struct {
        logic       rd;
        logic       en;
        logic [7:0] adr;
        logic [7:0] dat;
        logic       err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] ir_m = 16'h0000;
    logic        err_m = 1'b0;
    logic        poke_ir = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Response side of the scoreboard: every ACK pulse retires one expected transfer.
    always @(negedge CLK_IN) begin
        if (WB_ACK_O) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("mem_wr_en", MEM_WR_EN, e.en);
                check("err_at_ack", ERR_O, e.err);
                if (e.rd) begin
                    check("mem_wr_adr", MEM_WR_ADR, e.adr);
                    check("mem_wr_data", MEM_WR_DATA, e.dat);
                end
            end
        end else if (MEM_WR_EN) begin
            check("wr_en_without_ack", MEM_WR_EN, 32'd0);
        end
    end

    task automatic load_ir(input logic [15:0] d);
        MEM_RD_DATA = d;
        SM_READ_SELECT = 1'b1;
        @(posedge CLK_IN); #1;
        SM_READ_SELECT = 1'b0;
        ir_m = d;
    endtask

    task automatic do_xfer(input logic we, input logic wsel, input logic [7:0] ptr, input int delay,
                           input logic [7:0] rdata, input logic b2b, input logic hold, output int scyc);
        exp_t e;
        bit   got;
        bit   tmo;
        got = 0;
        scyc = 0;
        tmo = (delay < 0) || (delay >= TMO);
        if (tmo) err_m = 1'b1;
        e.rd  = ~we;
        e.en  = ~we & wsel;
        e.adr = ptr;
        e.dat = tmo ? 8'hFF : rdata;
        e.err = err_m;
        sb_q.push_back(e);
        SM_WRITE_SELECT = wsel;
        SM_INSTR_PTR = ptr;
        WB_WE_I = we;
        if (b2b) begin
            @(posedge CLK_IN); #1;
            check("b2b_idle_stb", WBS_STB_O, 1'b0);
        end else begin
            WB_CYC_I = 1'b1;
            WB_STB_I = 1'b1;
        end
        @(posedge CLK_IN); #1;
        check("stb_o", WBS_STB_O, 1'b1);
        check("cyc_o", WBS_CYC_O, 1'b1);
        check("we_o", WBS_WE_O, we);
        check("adr_o", WBS_ADR_O, ir_m[14:8]);
        check("dat_o", WBS_DAT_O, ir_m[7:0]);
        for (int i = 0; i < 40 && !got; i++) begin
            if (WBS_STB_O) scyc++;
            WBS_ACK_I = (i == delay);
            WBS_DAT_I = rdata;
            SM_READ_SELECT = poke_ir && (i == 0);
            MEM_RD_DATA = 16'h0000;
            @(posedge CLK_IN); #1;
            SM_READ_SELECT = 1'b0;
            if (WB_ACK_O) got = 1;
        end
        WBS_ACK_I = 1'b0;
        if (!got) check("ack_wait_expired", 32'd0, 32'd1);
        check("stb_drop_at_ack", WBS_STB_O, 1'b0);
        if (!hold) begin
            WB_CYC_I = 1'b0;
            WB_STB_I = 1'b0;
            @(posedge CLK_IN); #1;
            check("ack_one_cycle", WB_ACK_O, 1'b0);
            check("wr_en_one_cycle", MEM_WR_EN, 1'b0);
        end
    endtask

    logic [15:0] dec_ir[6]  = '{16'h0155, 16'h3F00, 16'h4000, 16'hCF12, 16'h5000, 16'h8100};
    logic [2:0]  dec_exp[6] = '{3'b100, 3'b000, 3'b001, 3'b011, 3'b000, 3'b110};

    initial begin
        int sc;
        repeat (2) @(posedge CLK_IN);
        #1;
        check("rst_stb", WBS_STB_O, 1'b0);
        check("rst_ack", WB_ACK_O, 1'b0);
        check("rst_rd_data", SM_READ_DATA, 8'h00);
        check("rst_jump", CONTROL_JUMP_REG_DCD, 1'b0);
        check("rst_err", ERR_O, 1'b0);
        RESET_IN = 1'b0;
        @(posedge CLK_IN); #1;

        // Decode table: jump, save, and both edges of the poll window.
        for (int i = 0; i < 6; i++) begin
            logic [15:0] d;
            logic [2:0]  x;
            d = dec_ir[i];
            x = dec_exp[i];
            load_ir(d);
            check("dcd_jump", CONTROL_JUMP_REG_DCD, x[2]);
            check("dcd_save", SAVE_REG_2_MEM, x[1]);
            check("dcd_poll", WB_BUSY_POLL_O, x[0]);
            check("dcd_data", SM_READ_DATA, d[7:0]);
        end

        // Write transfer, slave acks in the third strobe cycle; IR load attempt mid-transfer is ignored.
        load_ir(16'h4233);
        check("t2_poll", WB_BUSY_POLL_O, 1'b1);
        poke_ir = 1'b1;
        do_xfer(1'b1, 1'b0, 8'h00, 2, 8'h00, 1'b0, 1'b0, sc);
        poke_ir = 1'b0;
        check("t2_strobe_cycles", sc, 3);
        check("t2_ir_held", SM_READ_DATA, 8'h33);

        // Read with write-back.
        load_ir(16'h8510);
        do_xfer(1'b0, 1'b1, 8'h12, 0, 8'hA7, 1'b0, 1'b0, sc);
        check("t3_strobe_cycles", sc, 1);

        // Read without write-back still captures data.
        do_xfer(1'b0, 1'b0, 8'h55, 1, 8'h3C, 1'b0, 1'b0, sc);

        // Timeout.
        load_ir(16'h4A00);
        do_xfer(1'b0, 1'b1, 8'h20, -1, 8'h00, 1'b0, 1'b0, sc);
        check("t4_strobe_cycles", sc, TMO);
        check("t4_err_sticky", ERR_O, 1'b1);
        ERR_CLR_I = 1'b1;
        @(posedge CLK_IN); #1;
        ERR_CLR_I = 1'b0;
        err_m = 1'b0;
        check("t4_err_clr", ERR_O, 1'b0);

        // Ack on the timeout cycle is a normal completion.
        do_xfer(1'b0, 1'b1, 8'h21, TMO - 1, 8'h5A, 1'b0, 1'b0, sc);
        check("tmo_edge_cycles", sc, TMO);
        check("tmo_edge_no_err", ERR_O, 1'b0);

        // Back-to-back: write, then read request held through ACKD.
        load_ir(16'h0A5C);
        do_xfer(1'b1, 1'b0, 8'h00, 1, 8'h00, 1'b0, 1'b1, sc);
        do_xfer(1'b0, 1'b1, 8'h34, 0, 8'hC3, 1'b1, 1'b0, sc);

        // Abort: CYC_I drops mid-transfer, no ACK.
        WB_CYC_I = 1'b1;
        WB_STB_I = 1'b1;
        WB_WE_I = 1'b0;
        @(posedge CLK_IN); #1;
        WB_CYC_I = 1'b0;
        WB_STB_I = 1'b0;
        @(posedge CLK_IN); #1;
        check("abort_stb", WBS_STB_O, 1'b0);
        check("abort_ack", WB_ACK_O, 1'b0);

        // Asynchronous reset during XFER.
        load_ir(16'h4C77);
        WB_CYC_I = 1'b1;
        WB_STB_I = 1'b1;
        WB_WE_I = 1'b1;
        @(posedge CLK_IN); #1;
        check("t6_stb_before", WBS_STB_O, 1'b1);
        #2;
        RESET_IN = 1'b1;
        #1;
        check("t6_stb", WBS_STB_O, 1'b0);
        check("t6_cyc", WBS_CYC_O, 1'b0);
        check("t6_we", WBS_WE_O, 1'b0);
        check("t6_ack", WB_ACK_O, 1'b0);
        check("t6_poll", WB_BUSY_POLL_O, 1'b0);
        check("t6_rd_data", SM_READ_DATA, 8'h00);
        WB_CYC_I = 1'b0;
        WB_STB_I = 1'b0;
        @(posedge CLK_IN); #1;
        RESET_IN = 1'b0;
        repeat (5) @(posedge CLK_IN);
        #1;
        check("t6_idle_stb", WBS_STB_O, 1'b0);
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
